// File: rtl/tpu_ifb_pkg.sv
// tpu_ifb_pkg: shared types and constants for the instruction fetch buffer
package tpu_ifb_pkg;
  localparam int IFB_DEPTH = 32;
  localparam int IFB_ADDR_W = 5;
  localparam int INSTR_W = 32;
  localparam logic [7:0] OP_HALT = 8'hFF;
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} ifb_state_e;
endpackage

// File: rtl/ifb_ram.sv
// ifb_ram: simple dual-port synchronous RAM, one write port, one registered read port, no reset
module ifb_ram #(
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5,
  parameter int W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]      i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [W-1:0]      o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  // write port and registered read port; read data holds when not enabled
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: instruction store fetched sequentially to the controller; optional IFB_STALL_CNT_EN adds a stall counter
module instr_fetch_buffer
  import tpu_ifb_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH,
  parameter int ADDR_W = IFB_ADDR_W,
  parameter int INSTR_W = tpu_ifb_pkg::INSTR_W,
  parameter logic [7:0] HALT_OPCODE = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_wr_en,
  input  logic [ADDR_W-1:0]  instr_wr_addr,
  input  logic [INSTR_W-1:0] instr_wr_data,
  input  logic               start_execution,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               busy,
  output logic               done,
  output logic               wr_blocked,
  output logic [15:0]        stall_count
);
  ifb_state_e r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic r_wr_blocked;
  logic [INSTR_W-1:0] w_rd_data;
  logic w_halt, w_valid;

  assign w_halt = w_rd_data[INSTR_W-1 -: 8] == HALT_OPCODE;
  assign w_valid = r_state == PRESENT && !w_halt;

  ifb_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(INSTR_W)) u_ram (
    .clk     (clk),
    .i_we    (instr_wr_en && r_state == IDLE),
    .i_waddr (instr_wr_addr),
    .i_wdata (instr_wr_data),
    .i_re    (r_state == FETCH),
    .i_raddr (r_pc),
    .o_rdata (w_rd_data)
  );

  // state, program counter and dropped-write pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_wr_blocked <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
      r_wr_blocked <= instr_wr_en && r_state != IDLE;
    end
  end

  // next-state: HALT is swallowed in PRESENT, last entry terminates without wrap
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt = r_pc;
    case (r_state)
      IDLE: if (start_execution) begin
        w_state_nxt = FETCH;
        w_pc_nxt = '0;
      end
      FETCH: w_state_nxt = PRESENT;
      PRESENT: if (w_halt) w_state_nxt = DONE;
        else if (instr_ready) begin
          w_state_nxt = r_pc == ADDR_W'(DEPTH - 1) ? DONE : FETCH;
          w_pc_nxt = r_pc == ADDR_W'(DEPTH - 1) ? r_pc : r_pc + ADDR_W'(1);
        end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign instr_valid = w_valid;
  assign instr_data = w_valid ? w_rd_data : '0;
  assign instr_pc = w_valid ? r_pc : '0;
  assign busy = r_state == FETCH || r_state == PRESENT;
  assign done = r_state == DONE;
  assign wr_blocked = r_wr_blocked;

`ifdef IFB_STALL_CNT_EN
  logic [15:0] r_stall;
  // saturating count of presented-but-not-accepted cycles, cleared on accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) r_stall <= '0;
    else if (start_execution && r_state == IDLE) r_stall <= '0;
    else if (w_valid && !instr_ready && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end
  assign stall_count = r_stall;
`else
  assign stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: scoreboard bench for instr_fetch_buffer
module tb_instr_fetch_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic instr_wr_en = 1'b0;
  logic [4:0] instr_wr_addr = '0;
  logic [31:0] instr_wr_data = '0;
  logic start_execution = 1'b0;
  logic instr_ready = 1'b0;
  logic instr_valid, busy, done, wr_blocked;
  logic [31:0] instr_data;
  logic [4:0] instr_pc;
  logic [15:0] stall_count;
  logic [36:0] sb_q[$];
  int n_chk = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic p_stall = 1'b0;
  logic [36:0] p_word = '0;

  instr_fetch_buffer dut (
    .clk(clk), .rst_n(rst_n), .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data), .start_execution(start_execution), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_pc(instr_pc), .busy(busy),
    .done(done), .wr_blocked(wr_blocked), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    instr_wr_en = 1'b1;
    instr_wr_addr = a;
    instr_wr_data = d;
    tick;
    instr_wr_en = 1'b0;
  endtask

  task automatic start;
    start_execution = 1'b1;
    tick;
    start_execution = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (!done && n < max) begin
      tick;
      n++;
    end
    chk("done_seen", done, 1);
    tick;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  // handshake scoreboard, hold stability and HALT-never-presented checks
  always @(negedge clk) begin
    if (p_stall) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_word", {instr_pc, instr_data}, p_word);
    end
    if (instr_valid) chk("halt_presented", instr_data[31:24] == 8'hFF, 0);
    if (instr_valid && instr_ready) begin
      hs_cnt++;
      if (sb_q.size() == 0) chk("extra_valid", {instr_pc, instr_data}, 0);
      else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        chk("hs_pc", instr_pc, e[36:32]);
        chk("hs_data", instr_data, e[31:0]);
      end
    end
    p_stall = instr_valid && !instr_ready && rst_n;
    p_word = {instr_pc, instr_data};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h0;
    logic [6:0] ev, ed, eb;
    tick;
    tick;
    chk("rst_valid", instr_valid, 0);
    chk("rst_outs", {instr_data, instr_pc, busy, done, wr_blocked, stall_count}, 0);
    rst_n = 1'b1;
    tick;
    // program with HALT at 2, ready always high
    wr(0, 32'h10000001);
    wr(1, 32'h20000002);
    wr(2, 32'hFF000000);
    sb_q.push_back({5'd0, 32'h10000001});
    sb_q.push_back({5'd1, 32'h20000002});
    instr_ready = 1'b1;
    start;
    ev = 7'b0001010;
    ed = 7'b1000000;
    eb = 7'b0111111;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("seq_valid%0d", i), instr_valid, ev[i]);
      chk($sformatf("seq_done%0d", i), done, ed[i]);
      chk($sformatf("seq_busy%0d", i), busy, eb[i]);
      if (i < 6) tick;
    end
    tick;
    chk("t1_done_drop", {busy, done}, 0);
    chk("t1_sb_empty", sb_q.size(), 0);
    // same program, 5 stall cycles on pc 0
    sb_q.push_back({5'd0, 32'h10000001});
    sb_q.push_back({5'd1, 32'h20000002});
    instr_ready = 1'b0;
    start;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("stall_word", {instr_valid, instr_pc, instr_data}, {1'b1, 5'd0, 32'h10000001});
      tick;
    end
    instr_ready = 1'b1;
    wait_done(20);
`ifdef IFB_STALL_CNT_EN
    chk("stall_count", stall_count, 5);
`else
    chk("stall_count", stall_count, 0);
`endif
    chk("t2_sb_empty", sb_q.size(), 0);
    // full 32-entry program without HALT
    for (int i = 0; i < 32; i++) wr(5'(i), 32'h01000000 + i);
    for (int i = 0; i < 32; i++) sb_q.push_back({5'(i), 32'h01000000 + i});
    h0 = hs_cnt;
    start;
    wait_done(200);
    chk("t3_hs_count", hs_cnt - h0, 32);
    tick;
    tick;
    chk("t3_no_33rd", instr_valid, 0);
    chk("t3_sb_empty", sb_q.size(), 0);
    // write and start while busy are dropped
    for (int i = 0; i < 32; i++) sb_q.push_back({5'(i), 32'h01000000 + i});
    instr_ready = 1'b0;
    start;
    tick;
    wr(5, 32'hDEADBEEF);
    chk("wr_blocked_pulse", wr_blocked, 1);
    tick;
    chk("wr_blocked_clear", wr_blocked, 0);
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    tick;
    start;
    chk("busy_start_ignored", {instr_valid, instr_pc}, {1'b1, 5'd1});
    instr_ready = 1'b1;
    wait_done(200);
    chk("t4_sb_empty", sb_q.size(), 0);
    // HALT written in the same cycle as start
    h0 = hs_cnt;
    instr_wr_en = 1'b1;
    instr_wr_addr = 5'd0;
    instr_wr_data = 32'hFF000000;
    start_execution = 1'b1;
    tick;
    instr_wr_en = 1'b0;
    start_execution = 1'b0;
    chk("t5_fetch", {instr_valid, busy, done}, 3'b010);
    tick;
    chk("t5_present", {instr_valid, busy, done}, 3'b010);
    tick;
    chk("t5_done", {instr_valid, busy, done}, 3'b001);
    tick;
    chk("t5_idle", {instr_valid, busy, done}, 3'b000);
    chk("t5_no_hs", hs_cnt - h0, 0);
    // reset during PRESENT at pc 3, then re-run retained program
    for (int i = 0; i < 5; i++) wr(5'(i), 32'h0A000000 + i);
    wr(5, 32'hFF000000);
    for (int i = 0; i < 3; i++) sb_q.push_back({5'(i), 32'h0A000000 + i});
    instr_ready = 1'b1;
    start;
    for (int n = 0; n < 40 && !(instr_valid && instr_pc == 5'd3); n++) tick;
    instr_ready = 1'b0;
    chk("t6_at_pc3", {instr_valid, instr_pc}, {1'b1, 5'd3});
    rst_n = 1'b0;
    tick;
    chk("t6_rst_outs", {instr_valid, instr_data, instr_pc, busy, done, wr_blocked, stall_count}, 0);
    rst_n = 1'b1;
    tick;
    chk("t6_no_done", {busy, done}, 0);
    chk("t6_sb_empty", sb_q.size(), 0);
    for (int i = 0; i < 5; i++) sb_q.push_back({5'(i), 32'h0A000000 + i});
    instr_ready = 1'b1;
    start;
    wait_done(100);
    chk("t6_rerun_sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- 32-entry × 32-bit instruction store, written by the UART DMA engine over its instruction write port (instr_wr_en/addr/data).
- On a start_execution pulse it fetches instructions sequentially from address 0 and presents them to the TPU controller through a valid/ready handshake.
- The sequence stops at a HALT opcode or at the last entry. Completion is reported with busy/done, which feed the host status path.

Parameters:
- DEPTH, 32, number of instruction entries (power of two).
- ADDR_W, 5, log2(DEPTH).
- INSTR_W, 32, instruction width; opcode is bits [INSTR_W-1:INSTR_W-8].
- HALT_OPCODE, 8'hFF, opcode that terminates the program.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- instr_wr_en  in  1  write strobe from DMA.
- instr_wr_addr  in  ADDR_W  write address.
- instr_wr_data  in  INSTR_W  write data.
- start_execution  in  1  one-cycle start pulse.
- instr_valid  out  1  instr_data/instr_pc are valid.
- instr_ready  in  1  controller accepts the instruction.
- instr_data  out  INSTR_W  current instruction.
- instr_pc  out  ADDR_W  address of the current instruction.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.
- wr_blocked  out  1  one-cycle pulse: a write was dropped because busy.
- stall_count  out  16  see Optional Feature.

Behaviour:
- Reset (rst_n low at a clock edge) values: state IDLE, pc=0, instr_valid=0, instr_data=0, instr_pc=0, busy=0, done=0, wr_blocked=0, stall_count=0.
- Reset does not clear RAM contents; they are undefined after power-up.
- Reset mid-program aborts immediately, with no done pulse.
- Writes:
  - In IDLE, instr_wr_en writes RAM[instr_wr_addr] at that edge.
  - While busy, the write is ignored and wr_blocked pulses on the next cycle.
- State machine:
  - IDLE: start_execution → FETCH with pc=0 and busy=1. A start while not in IDLE is ignored.
  - FETCH: drive RAM read address = pc (synchronous read, 1-cycle latency) → PRESENT.
  - PRESENT, opcode == HALT_OPCODE: instr_valid stays 0 and the HALT is never presented → DONE.
  - PRESENT, otherwise: instr_valid=1, instr_data=RAM word, instr_pc=pc. Hold all three stable while instr_ready=0.
  - PRESENT, on instr_valid && instr_ready: instr_valid=0. If pc==DEPTH-1 → DONE (no wrap); else pc=pc+1 → FETCH.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Latency:
  - start sampled at cycle T → instr_valid first high at T+2.
  - Handshake at cycle N → next instr_valid high at N+2; one bubble per instruction, so throughput is 1 instruction per 2 cycles.
  - HALT in PRESENT at cycle M → done high at M+1.
- Same-cycle write and start in IDLE: the write is committed before the FETCH read, so the new data is seen.
- instr_ready while instr_valid=0 is ignored.
- pc arithmetic is ADDR_W-bit; wrap is unreachable because of the DEPTH-1 terminate rule.

Optional Feature:
- Macro IFB_STALL_CNT_EN.
- Defined:
  - stall_count increments on each cycle with instr_valid && !instr_ready.
  - Saturates at 16'hFFFF; cleared to 0 when start is accepted.
  - Holds its value after done until the next start.
- Undefined: stall_count is tied to 16'h0000 and no counter logic exists.

Decomposition:
- Shared package tpu_ifb_pkg: state enum (IDLE, FETCH, PRESENT, DONE), OP_HALT=8'hFF, IFB_DEPTH=32, IFB_ADDR_W=5, INSTR_W=32.
- One sub-module, ifb_ram: simple dual-port synchronous RAM with 1 write port and 1 registered read port, no reset.

Test Plan:
- Write 3 words: 0x10000001@0, 0x20000002@1, 0xFF000000@2; start with instr_ready=1 → instr_valid at T+2 with pc 0 then 1, data 0x10000001 then 0x20000002, 2 cycles apart. Then done pulses once, busy falls, and HALT is never presented.
- Same program, instr_ready=0 for 5 cycles on pc 0 → instr_data/instr_pc stay stable. With IFB_STALL_CNT_EN, stall_count=5 after done; without it, 0.
- Fill all 32 entries with 0x01000000+i (no HALT) → 32 handshakes with pc 0..31, then done; no 33rd valid.
- Write to addr 5 while busy → wr_blocked pulses; RAM[5] is unchanged on a re-run. A start while busy is ignored (pc not reset).
- Write 0xFF000000@0 in the same cycle as start → immediate done at T+3 (start at T, PRESENT at T+2), instr_valid never asserted.
- Assert rst_n=0 during PRESENT at pc 3 → next cycle everything is idle with all outputs 0 and no done. A re-start executes the retained program from pc 0.
